// File: rtl/hamming_pkg.sv
// Shared constants and types for the SEC-DED (8,4) extended-Hamming code.
// The upstream encoder uses the same bit map, so keep the two in step.
package hamming_pkg;
    localparam int CW_W   = 8;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_CORR   = 2'd1;
    localparam logic [1:0] ERR_PARITY = 2'd2;
    localparam logic [1:0] ERR_DOUBLE = 2'd3;

    // c[k] is Hamming position k+1; p0 sits on top as overall parity
    localparam int P1_POS = 0;
    localparam int P2_POS = 1;
    localparam int D0_POS = 2;
    localparam int P4_POS = 3;
    localparam int D1_POS = 4;
    localparam int D2_POS = 5;
    localparam int D3_POS = 6;
    localparam int P0_POS = 7;

    // stage-1 payload: raw codeword plus its check results
    typedef struct packed {
        logic [CW_W-1:0]  cw;
        logic [SYN_W-1:0] syn;
        logic             pe;
    } s1_t;

    // stage-2 payload: what the consumer sees
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        err;
        logic [SYN_W-1:0]  syn;
    } s2_t;

    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        return {cw[D3_POS], cw[D2_POS], cw[D1_POS], cw[D0_POS]};
    endfunction
endpackage

// File: rtl/hamming_syndrome.sv
// Pure combinational syndrome / overall-parity generator. Kept standalone so
// checkers can reuse it on any codeword.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]  cw,
    output logic [SYN_W-1:0] syn,
    output logic             pe
);
    assign syn[0] = cw[P1_POS] ^ cw[D0_POS] ^ cw[D1_POS] ^ cw[D3_POS];
    assign syn[1] = cw[P2_POS] ^ cw[D0_POS] ^ cw[D2_POS] ^ cw[D3_POS];
    assign syn[2] = cw[P4_POS] ^ cw[D1_POS] ^ cw[D2_POS] ^ cw[D3_POS];
    assign pe     = ^cw;
endmodule

// File: rtl/hamming_decoder.sv
// SEC-DED (8,4) decoder: 2-stage valid/ready pipeline with saturating
// corrected / uncorrectable counters and a sticky double-error flag.
module hamming_decoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CW_W-1:0]    in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [1:0]         out_err,
    output logic [SYN_W-1:0]   out_syn,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   corr_cnt,
    output logic [CNT_W-1:0]   uncorr_cnt,
    output logic               dbl_seen
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic v1, v2;
    logic adv2, hs;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic [CW_W-1:0] flip_mask;

    hamming_syndrome u_syn (
        .cw  (in_data),
        .syn (s1_d.syn),
        .pe  (s1_d.pe)
    );
    assign s1_d.cw = in_data;

    // stage 2 moves when empty or drained; stage 1 moves when empty or stage 2 moves
    assign adv2     = ~v2 | out_ready;
    assign in_ready = ~v1 | adv2;
    assign hs       = v2 & out_ready;

    // classify stage-1 word and correct a single error inside c[6:0]
    always_comb begin
        flip_mask = '0;
        s2_d.syn  = s1_q.syn;
        s2_d.err  = ERR_NONE;
        if (s1_q.syn == '0) begin
            s2_d.err = s1_q.pe ? ERR_PARITY : ERR_NONE;
        end else if (s1_q.pe) begin
            s2_d.err  = ERR_CORR;
            flip_mask = CW_W'(1) << (s1_q.syn - SYN_W'(1));
        end else begin
            s2_d.err = ERR_DOUBLE;
        end
        s2_d.data = extract_data(s1_q.cw ^ flip_mask);
    end

    // stage 1: capture codeword and check bits on an input handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            s1_q <= '0;
        end else if (in_ready) begin
            v1 <= in_valid;
            if (in_valid)
                s1_q <= s1_d;
        end
    end

    // stage 2: capture decoded word; holds while stalled so outputs stay stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2   <= 1'b0;
            s2_q <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1)
                s2_q <= s2_d;
        end
    end

    assign out_valid = v2;
    assign out_data  = s2_q.data;
    assign out_err   = s2_q.err;
    assign out_syn   = s2_q.syn;

    // statistics on output handshakes; clear wins over counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
            dbl_seen   <= 1'b0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
            dbl_seen   <= 1'b0;
        end else if (hs) begin
            case (s2_q.err)
                ERR_CORR, ERR_PARITY: begin
                    if (corr_cnt != CNT_MAX)
                        corr_cnt <= corr_cnt + 1'b1;
                end
                ERR_DOUBLE: begin
                    if (uncorr_cnt != CNT_MAX)
                        uncorr_cnt <= uncorr_cnt + 1'b1;
                    dbl_seen <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: clean/single/double words, backpressure,
// counter saturation and clear priority, mid-stream reset.
module tb_hamming_decoder;
    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready, cnt_clr;
    logic [7:0] in_data;
    logic       in_ready, out_valid, dbl_seen;
    logic [3:0] out_data;
    logic [1:0] out_err;
    logic [2:0] out_syn;
    logic [7:0] corr_cnt, uncorr_cnt;
    logic       in_ready_s, out_valid_s, dbl_seen_s;
    logic [3:0] out_data_s;
    logic [1:0] out_err_s;
    logic [2:0] out_syn_s;
    logic [1:0] corr_cnt_s, uncorr_cnt_s;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    hamming_decoder #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_err(out_err),
        .out_syn(out_syn), .out_valid(out_valid), .out_ready(out_ready),
        .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt),
        .dbl_seen(dbl_seen)
    );

    hamming_decoder #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_s), .out_data(out_data_s), .out_err(out_err_s),
        .out_syn(out_syn_s), .out_valid(out_valid_s), .out_ready(out_ready),
        .cnt_clr(cnt_clr), .corr_cnt(corr_cnt_s), .uncorr_cnt(uncorr_cnt_s),
        .dbl_seen(dbl_seen_s)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // one word through an idle pipeline; called and returns at posedge+1
    task automatic xfer(input string tag, input logic [7:0] cw,
                        input logic [3:0] ed, input logic [1:0] ee, input logic [2:0] es);
        in_data   = cw;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({tag, ".rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, ".early"}, out_valid, 0);
        @(posedge clk); #1;
        chk({tag, ".vld"}, out_valid, 1);
        chk({tag, ".data"}, out_data, ed);
        chk({tag, ".err"}, out_err, ee);
        chk({tag, ".syn"}, out_syn, es);
        @(posedge clk); #1;
    endtask

    logic [7:0] bp_in  [4];
    logic [3:0] bp_dat [4];
    logic [1:0] bp_err [4];

    initial begin
        int idx, oidx;
        logic saw_block, prev_stall;
        logic [3:0] prev_data;
        logic [1:0] prev_err;
        logic [2:0] prev_syn;

        bp_in  = '{8'h55, 8'h54, 8'h44, 8'h55};
        bp_dat = '{4'hB, 4'hB, 4'h9, 4'hB};
        bp_err = '{2'd0, 2'd1, 2'd3, 2'd0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", out_valid, 0);
        chk("rst.ready", in_ready, 1);
        chk("rst.data", out_data, 0);
        chk("rst.cnt", {corr_cnt, uncorr_cnt, 7'd0, dbl_seen}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // clean and single-error words
        xfer("clean", 8'h55, 4'hB, 2'd0, 3'd0);
        chk("clean.corr", corr_cnt, 0);
        chk("clean.uncorr", uncorr_cnt, 0);
        xfer("c0", 8'h54, 4'hB, 2'd1, 3'd1);
        xfer("c4", 8'h45, 4'hB, 2'd1, 3'd5);
        xfer("c7", 8'hD5, 4'hB, 2'd2, 3'd0);
        chk("single.corr", corr_cnt, 3);
        chk("single.uncorr", uncorr_cnt, 0);

        // double error, then sticky flag survives a clean word
        xfer("dbl", 8'h44, 4'h9, 2'd3, 3'd4);
        chk("dbl.uncorr", uncorr_cnt, 1);
        chk("dbl.seen", dbl_seen, 1);
        xfer("after", 8'h55, 4'hB, 2'd0, 3'd0);
        chk("after.seen", dbl_seen, 1);
        chk("after.corr", corr_cnt, 3);

        // plain clear
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr.corr", corr_cnt, 0);
        chk("clr.seen", dbl_seen, 0);

        // saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) xfer("sat", 8'h54, 4'hB, 2'd1, 3'd1);
        chk("sat.corr2", corr_cnt_s, 3);
        chk("sat.corr8", corr_cnt, 5);

        // clear coinciding with a class-3 handshake
        xfer("pre", 8'h44, 4'h9, 2'd3, 3'd4);
        chk("pre.uncorr", uncorr_cnt, 1);
        in_data = 8'h44; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("clrhs.vld", out_valid, 1);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clrhs.uncorr", uncorr_cnt, 0);
        chk("clrhs.seen", dbl_seen, 0);
        chk("clrhs.corr", corr_cnt, 0);
        chk("clrhs.drained", out_valid, 0);

        // backpressure: out_ready low for cycles 3..5
        idx = 0; oidx = 0; saw_block = 1'b0; prev_stall = 1'b0;
        prev_data = '0; prev_err = '0; prev_syn = '0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            in_valid  = (idx < 4);
            in_data   = (idx < 4) ? bp_in[idx] : 8'h00;
            out_ready = !(cyc >= 3 && cyc <= 5);
            #1;
            if (prev_stall) begin
                chk("bp.hold", {out_data, out_err, out_syn}, {prev_data, prev_err, prev_syn});
            end
            if (!in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                if (oidx < 4) begin
                    chk("bp.data", out_data, bp_dat[oidx]);
                    chk("bp.err", out_err, bp_err[oidx]);
                end else begin
                    chk("bp.extra", oidx, 3);
                end
                oidx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data; prev_err = out_err; prev_syn = out_syn;
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp.block", saw_block, 1);
        chk("bp.accepted", idx, 4);
        chk("bp.emitted", oidx, 4);
        chk("bp.corr", corr_cnt, 1);
        chk("bp.uncorr", uncorr_cnt, 1);

        // fill both stages, then reset mid-stream
        out_ready = 1'b0;
        in_data = 8'h55; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 8'h54;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("full.ready", in_ready, 0);
        chk("full.vld", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mrst.valid", out_valid, 0);
        chk("mrst.ready", in_ready, 1);
        chk("mrst.out", {out_data, out_err, out_syn}, 0);
        chk("mrst.cnt", {corr_cnt, uncorr_cnt, 7'd0, dbl_seen}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xfer("post", 8'h45, 4'hB, 2'd1, 3'd5);
        chk("post.corr", corr_cnt, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/hamming_decoder.md
# hamming_decoder

SEC-DED (8,4) extended-Hamming decoder sitting directly downstream of the error-injection stage. It accepts the 8-bit codeword, which may carry deliberately flipped bits, through a 2-stage valid/ready pipeline. It emits the corrected 4-bit nibble with an error classification, and keeps saturating counts of corrected and uncorrectable words.

## Interface
- `CNT_W`, 8: width of each error counter.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_data` in 8: codeword from the error-injection stage.
- `in_valid` in 1: `in_data` is valid this cycle.
- `in_ready` out 1: decoder accepts `in_data` this cycle.
- `out_data` out 4: corrected nibble {d3,d2,d1,d0}.
- `out_err` out 2: error class: 0 none, 1 single corrected in c[6:0], 2 single in overall-parity bit c[7], 3 double / uncorrectable.
- `out_syn` out 3: syndrome {s4,s2,s1} of the word on `out_data`.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accepts the output.
- `cnt_clr` in 1: synchronous clear of counters and the sticky flag.
- `corr_cnt` out CNT_W: count of words with class 1 or 2.
- `uncorr_cnt` out CNT_W: count of words with class 3.
- `dbl_seen` out 1: sticky; set on the first class-3 word.

## Operation
- Codeword bit map: c[0]=p1, c[1]=p2, c[2]=d0, c[3]=p4, c[4]=d1, c[5]=d2, c[6]=d3, c[7]=p0.
- c[k] is Hamming position k+1.
- p0 gives even parity over all 8 bits.
- Syndrome:
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s4 = c3^c4^c5^c6
- pe = XOR of c[7:0].
- Classification and action:
  - s=0, pe=0: class 0; data passed unchanged.
  - s≠0, pe=1: class 1; flip c[s-1], then extract data.
  - s=0, pe=1: class 2; data passed unchanged.
  - s≠0, pe=0: class 3; data passed uncorrected.
- Stage 1 registers the codeword, s and pe.
- Stage 2 registers the corrected nibble, class and syndrome.
- Handshake:
  - v1/v2 are the stage valid bits; `out_valid` = v2.
  - stage-2 advance: adv2 = ~v2 | out_ready.
  - `in_ready` = ~v1 | adv2 (combinational).
  - Input accepted on in_valid & in_ready.
  - When a stage does not advance, it holds its payload.
- Counter and flag updates occur only on an output handshake (out_valid & out_ready):
  - `corr_cnt` +1 for class 1 or 2.
  - `uncorr_cnt` +1 for class 3, and `dbl_seen` is set.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `cnt_clr` has priority: in a cycle with both `cnt_clr` and a handshake, the counters and `dbl_seen` become 0 and that word is not counted.
- `cnt_clr` does not affect the pipeline.

## Timing
- Latency is 2 cycles: a word accepted at edge N is presented with `out_valid`=1 after edge N+2 when no stall occurs.
- Throughput is 1 word/cycle while `out_ready`=1.
- Stall with `out_ready`=0:
  - stage 2 holds; stage 1 fills.
  - `in_ready` drops once v1=v2=1.
  - No word is lost or duplicated.
- `out_data`, `out_err` and `out_syn` remain stable while out_valid & ~out_ready.
- Reset (asynchronous, active-high, at any time including mid-stream):
  - v1=v2=0; in-flight words are discarded.
  - `out_data`=0, `out_err`=0, `out_syn`=0.
  - `corr_cnt`=0, `uncorr_cnt`=0, `dbl_seen`=0.
  - `in_ready` reads 1 as soon as reset asserts.

## Structure
- Package `hamming_pkg` holds:
  - error-class constants ERR_NONE=0, ERR_CORR=1, ERR_PARITY=2, ERR_DOUBLE=3;
  - the syndrome width (3);
  - the bit-position constants for p1/p2/d0/p4/d1/d2/d3/p0.
- The upstream encoder shares this package.
- One combinational sub-module, `hamming_syndrome` (8-bit codeword in; s and pe out), is instantiated in stage 1 and reusable by checkers.
- Pipeline and counters live in the top module.

## Test plan
- Clean word: in_data=8'h55 -> after 2 cycles out_data=4'hB, out_err=0, out_syn=0; counters unchanged.
- Single flips (only c[0] flipped, only c[4] flipped, only c[7] flipped):
  - 8'h54 -> out_data=4'hB, err=1, syn=1.
  - 8'h45 -> out_data=4'hB, err=1, syn=5.
  - 8'hD5 -> out_data=4'hB, err=2, syn=0.
  - corr_cnt=3 after these three words.
- Both flipped: 8'h44 -> err=3, syn=4, uncorr_cnt=1, dbl_seen=1; a subsequent clean word leaves dbl_seen=1.
- Backpressure:
  - Stream 8'h55,8'h54,8'h44,8'h55 with out_ready low for 3 cycles mid-stream.
  - in_ready falls with both stages full.
  - Outputs appear in order, with none dropped or duplicated.
  - Counters advance once per handshake.
- Saturation and clear:
  - With CNT_W=2, 5 class-1 words -> corr_cnt holds 3.
  - cnt_clr asserted in the same cycle as a class-3 handshake -> uncorr_cnt=0, dbl_seen=0.
- Reset mid-stream: assert rst with v1=v2=1 -> all outputs and counters 0 immediately; the first word after release emerges 2 cycles after acceptance.
